// File: rtl/mux_logic_pkg.sv
// Shared definitions for the mux-built logic pipeline: op codes and the per-stage control record.
package mux_logic_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOTA = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   // Occupancy and op code of one stage; the WIDTH-dependent data word sits beside it in the top.
   typedef struct packed {
      logic       valid;
      logic [2:0] op;
   } stage_meta_t;

endpackage

// File: rtl/mux2.sv
// 2:1 multiplexer, the only primitive the logic unit's datapath is built from.
module mux2 (
   input  logic sel,
   input  logic d0,
   input  logic d1,
   output logic y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_pipe.sv
// Pipelined N-bit logic unit built from mux2 cells, with valid/ready handshake and collapsing bubbles.
// Optional macro MUX_LOGIC_PIPE_PARITY_EN adds y_par, the mux-chain parity of each result.
module mux_logic_pipe
   import mux_logic_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [2:0]       y_op,
   output logic             busy
`ifdef MUX_LOGIC_PIPE_PARITY_EN
   ,
   output logic             y_par
`endif
);

   logic [WIDTH-1:0]  res;
   logic [STAGES-1:0] adv;
   logic              drain_acc;
   stage_meta_t       meta_q [STAGES];
   logic [WIDTH-1:0]  data_q [STAGES];

   // Each bit: pick f(a,0) and f(a,1) by op through 8:1 mux trees, then let b[i] choose between them.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic       na, f0, f1;
      logic [7:0] c0, c1;
      logic [3:0] l1_0, l1_1;
      logic [1:0] l2_0, l2_1;

      mux2 u_inv (.sel(a[i]), .d0(1'b1), .d1(1'b0), .y(na));

      always_comb begin
         c0 = '0;
         c1 = '0;
         c0[OP_AND]  = 1'b0;  c1[OP_AND]  = a[i];
         c0[OP_OR]   = a[i];  c1[OP_OR]   = 1'b1;
         c0[OP_NAND] = 1'b1;  c1[OP_NAND] = na;
         c0[OP_NOR]  = na;    c1[OP_NOR]  = 1'b0;
         c0[OP_XOR]  = a[i];  c1[OP_XOR]  = na;
         c0[OP_XNOR] = na;    c1[OP_XNOR] = a[i];
         c0[OP_NOTA] = na;    c1[OP_NOTA] = na;
         c0[OP_PASS] = a[i];  c1[OP_PASS] = a[i];
      end

      for (genvar j = 0; j < 4; j++) begin : g_l1
         mux2 u_m0 (.sel(op[0]), .d0(c0[2*j]), .d1(c0[2*j+1]), .y(l1_0[j]));
         mux2 u_m1 (.sel(op[0]), .d0(c1[2*j]), .d1(c1[2*j+1]), .y(l1_1[j]));
      end
      for (genvar j = 0; j < 2; j++) begin : g_l2
         mux2 u_m0 (.sel(op[1]), .d0(l1_0[2*j]), .d1(l1_0[2*j+1]), .y(l2_0[j]));
         mux2 u_m1 (.sel(op[1]), .d0(l1_1[2*j]), .d1(l1_1[2*j+1]), .y(l2_1[j]));
      end
      mux2 u_l3_0 (.sel(op[2]), .d0(l2_0[0]), .d1(l2_0[1]), .y(f0));
      mux2 u_l3_1 (.sel(op[2]), .d0(l2_1[0]), .d1(l2_1[1]), .y(f1));
      mux2 u_b    (.sel(b[i]),  .d0(f0),      .d1(f1),      .y(res[i]));
   end

`ifdef MUX_LOGIC_PIPE_PARITY_EN
   logic              par_res;
   logic [STAGES-1:0] par_q;

   // Running parity: each result bit either passes or inverts the parity so far.
   for (genvar i = 0; i < WIDTH; i++) begin : g_par
      logic p;
      if (i == 0) begin : g_first
         assign p = res[0];
      end else begin : g_next
         logic np;
         mux2 u_np (.sel(g_par[i-1].p), .d0(1'b1), .d1(1'b0), .y(np));
         mux2 u_x  (.sel(res[i]), .d0(g_par[i-1].p), .d1(np), .y(p));
      end
   end
   assign par_res = g_par[WIDTH-1].p;
   assign y_par   = par_q[STAGES-1];
`endif

   // A stage may load when it, or any stage after it, is empty, or when the output is being taken.
   always_comb begin
      drain_acc = out_ready;
      busy      = 1'b0;
      adv       = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         drain_acc = drain_acc | !meta_q[k].valid;
         adv[k]    = drain_acc;
         busy      = busy | meta_q[k].valid;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = meta_q[STAGES-1].valid;
   assign y         = data_q[STAGES-1];
   assign y_op      = meta_q[STAGES-1].op;

   // Stage boundary: data and op move only with a valid beat; empty slots keep stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            meta_q[k] <= '0;
            data_q[k] <= '0;
`ifdef MUX_LOGIC_PIPE_PARITY_EN
            par_q[k]  <= 1'b0;
`endif
         end
      end else begin
         if (adv[0]) begin
            meta_q[0].valid <= in_valid;
            if (in_valid) begin
               meta_q[0].op <= op;
               data_q[0]    <= res;
`ifdef MUX_LOGIC_PIPE_PARITY_EN
               par_q[0]     <= par_res;
`endif
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               meta_q[k].valid <= meta_q[k-1].valid;
               if (meta_q[k-1].valid) begin
                  meta_q[k].op <= meta_q[k-1].op;
                  data_q[k]    <= data_q[k-1];
`ifdef MUX_LOGIC_PIPE_PARITY_EN
                  par_q[k]     <= par_q[k-1];
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_logic_pipe.sv
// Bench for mux_logic_pipe: vector tables, handshake corner sequences and a random scoreboard run.
`timescale 1ns/1ps
module tb_mux_logic_pipe;

   localparam int W = 8;
   localparam int S = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0] a, b, y;
   logic [2:0]   op, y_op;

   logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic         a1, b1, y1;
   logic [2:0]   op1, y_op1;
`ifdef MUX_LOGIC_PIPE_PARITY_EN
   logic         y_par, y_par1;
`endif

   mux_logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_op(y_op), .busy(busy)
`ifdef MUX_LOGIC_PIPE_PARITY_EN
      , .y_par(y_par)
`endif
   );

   mux_logic_pipe #(.WIDTH(1), .STAGES(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
      .y(y1), .y_op(y_op1), .busy(busy1)
`ifdef MUX_LOGIC_PIPE_PARITY_EN
      , .y_par(y_par1)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
      case (o)
         3'd0:    return x & z;
         3'd1:    return x | z;
         3'd2:    return ~(x & z);
         3'd3:    return ~(x | z);
         3'd4:    return x ^ z;
         3'd5:    return ~(x ^ z);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: order, values and minimum latency of every emitted beat, plus hold under stall.
   typedef struct {
      logic [W-1:0] y;
      logic [2:0]   op;
      int           n;
   } exp_t;
   exp_t         sb_q[$];
   exp_t         sb_e;
   int           edge_n = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_y;
   logic [2:0]   prev_op;

   always @(posedge clk) begin
      edge_n++;
      if (!rst_n) begin
         sb_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_y", y, prev_y);
            chk("hold_op", y_op, prev_op);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
            else begin
               sb_e = sb_q.pop_front();
               chk("sb_y", y, sb_e.y);
               chk("sb_op", y_op, sb_e.op);
               chk("sb_latency_ok", (edge_n - sb_e.n) >= S, 1);
`ifdef MUX_LOGIC_PIPE_PARITY_EN
               chk("sb_par", y_par, ^sb_e.y);
`endif
            end
         end
         if (in_valid && in_ready) sb_q.push_back('{ref_f(op, a, b), op, edge_n});
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
         prev_op    = y_op;
      end
   end

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a, b, ey;
      logic         ep;
   } vec_t;
   typedef struct {
      logic a, b, ey;
   } vec1_t;

   vec_t         tv  [13];
   vec1_t        tv1 [4];
   logic [W-1:0] bp  [4];
   logic [W-1:0] got [16];
   int           gotc[16];
   logic [W-1:0] ta[16], tb_[16];
   logic [2:0]   top_[16];
   int           idx, nout;
   logic         rdy;

   initial begin
      tv[0]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
      tv[1]  = '{3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0};
      tv[2]  = '{3'd2, 8'hF0, 8'h3C, 8'hCF, 1'b0};
      tv[3]  = '{3'd3, 8'hF0, 8'h3C, 8'h03, 1'b0};
      tv[4]  = '{3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0};
      tv[5]  = '{3'd5, 8'hF0, 8'h3C, 8'h33, 1'b0};
      tv[6]  = '{3'd6, 8'hF0, 8'h3C, 8'h0F, 1'b0};
      tv[7]  = '{3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0};
      tv[8]  = '{3'd6, 8'hA5, 8'h00, 8'h5A, 1'b0};
      tv[9]  = '{3'd7, 8'h07, 8'h00, 8'h07, 1'b1};
      tv[10] = '{3'd7, 8'h03, 8'hFF, 8'h03, 1'b0};
      tv[11] = '{3'd0, 8'hFF, 8'h0F, 8'h0F, 1'b0};
      tv[12] = '{3'd4, 8'h01, 8'h00, 8'h01, 1'b1};
      tv1[0] = '{1'b0, 1'b0, 1'b1};
      tv1[1] = '{1'b0, 1'b1, 1'b1};
      tv1[2] = '{1'b1, 1'b0, 1'b1};
      tv1[3] = '{1'b1, 1'b1, 1'b0};
      bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33; bp[3] = 8'h44;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = 1'b0; b1 = 1'b0; op1 = 3'd2;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_y", y, 0);
      chk("rst_y_op", y_op, 0);
`ifdef MUX_LOGIC_PIPE_PARITY_EN
      chk("rst_y_par", y_par, 0);
`endif
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      step();

      // 8-bit vector table, one isolated beat each.
      for (int i = 0; i < 13; i++) begin
         op = tv[i].op; a = tv[i].a; b = tv[i].b; in_valid = 1'b1;
         chk("tv_in_ready", in_ready, 1);
         step();
         in_valid = 1'b0;
         chk("tv_not_yet", out_valid, 0);
         step();
         chk("tv_valid", out_valid, 1);
         chk("tv_y", y, tv[i].ey);
         chk("tv_y_op", y_op, tv[i].op);
`ifdef MUX_LOGIC_PIPE_PARITY_EN
         chk("tv_y_par", y_par, tv[i].ep);
`endif
      end

      // 1-bit NAND sweep.
      for (int i = 0; i < 4; i++) begin
         a1 = tv1[i].a; b1 = tv1[i].b; in_valid1 = 1'b1;
         step();
         in_valid1 = 1'b0;
         chk("w1_not_yet", out_valid1, 0);
         step();
         chk("w1_valid", out_valid1, 1);
         chk("w1_y", y1, tv1[i].ey);
         chk("w1_y_op", y_op1, 2);
      end

      repeat (2) step();
      chk("idle_busy", busy, 0);

      // Backpressure: stall fills the pipe after two accepts, then release drains in order.
      idx = 0; nout = 0;
      for (int c = 0; c < 10; c++) begin
         out_ready = (c >= 4);
         if (idx < 4) begin in_valid = 1'b1; a = bp[idx]; b = '0; op = 3'd7; end
         else in_valid = 1'b0;
         #1;
         if (c == 1) chk("bp_ready_second", in_ready, 1);
         if (c == 2 || c == 3) begin
            chk("bp_full_ready", in_ready, 0);
            chk("bp_full_valid", out_valid, 1);
            chk("bp_hold_y", y, bp[0]);
            chk("bp_busy", busy, 1);
         end
         if (out_valid && out_ready) begin
            if (nout < 16) begin got[nout] = y; gotc[nout] = c; end
            nout++;
         end
         rdy = in_ready && in_valid;
         step();
         if (rdy) idx++;
      end
      chk("bp_count", nout, 4);
      for (int k = 0; k < 4; k++) begin
         chk("bp_order", got[k], bp[k]);
         chk("bp_cycle", gotc[k], 4 + k);
      end

      // Throughput: 16 back-to-back random beats.
      out_ready = 1'b1; nout = 0;
      for (int k = 0; k < 16; k++) begin
         ta[k] = W'($urandom); tb_[k] = W'($urandom); top_[k] = 3'($urandom);
      end
      for (int c = 0; c < 22; c++) begin
         if (c < 16) begin in_valid = 1'b1; a = ta[c]; b = tb_[c]; op = top_[c]; end
         else in_valid = 1'b0;
         #1;
         if (c < 16) chk("tp_in_ready", in_ready, 1);
         if (out_valid) begin
            if (nout < 16) begin got[nout] = y; gotc[nout] = c; end
            nout++;
         end
         step();
      end
      chk("tp_count", nout, 16);
      for (int k = 0; k < 16; k++) begin
         chk("tp_y", got[k], ref_f(top_[k], ta[k], tb_[k]));
         chk("tp_cycle", gotc[k], k + 2);
      end

      // Reset while the pipe is full and stalled.
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; a = W'(8'h5C + c); b = '0; op = 3'd7;
         step();
      end
      in_valid = 1'b0;
      chk("mr_full_valid", out_valid, 1);
      chk("mr_full_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", out_valid, 0);
      chk("mr_busy", busy, 0);
      chk("mr_y", y, 0);
      chk("mr_y_op", y_op, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      op = 3'd0; a = 8'hFF; b = 8'h0F; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("mr_new_valid", out_valid, 1);
      chk("mr_new_y", y, 8'h0F);
      step();
      chk("mr_no_extra", out_valid, 0);

      // Random traffic with a holding producer and random consumer stalls.
      rdy = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (!(in_valid && !rdy)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         rdy = in_ready;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (S + 3) step();
      chk("drain_sb_empty", sb_q.size(), 0);
      chk("drain_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

endmodule

// File: doc/mux_logic_pipe.md
Name: mux_logic_pipe

Overview:
- Parametrised, pipelined bitwise logic unit.
- Every gate function is built only from 2:1 multiplexers, with no native gate operators in the datapath.
- Successor to the single-bit mux-built NAND gate: it adds N-bit width, a runtime-selectable operation, a valid/ready handshake and a configurable number of register stages.
- Sits between an operand producer and a result consumer.

Parameters:
- WIDTH, 8, operand/result bit width (>=1).
- STAGES, 2, number of pipeline register stages (>=1); sets latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- y  output  WIDTH  result.
- y_op  output  3  op code that produced y.
- busy  output  1  any stage holds a valid beat.

Behaviour:
- Single clock domain on clk.
- Reset is asynchronous and active-low on rst_n.
- Reset values: all stage valid bits 0, so out_valid=0 and busy=0. y=0, y_op=0. in_ready=1 once rst_n is high.
- Op encoding (per bit i, result = b[i] ? f(a[i],1) : f(a[i],0), realised with mux2 instances):
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 NOT A (b ignored)
  - 7 PASS A (b ignored)
- All 8 codes are defined; there are no reserved values.
- Inversion (~a) is also produced via a mux: sel=a, d0=1, d1=0.
- Evaluation: the logic result is computed combinationally from a/b/op and captured into stage 0 together with op.
- Pipeline: stages 0..STAGES-1, each holding {valid, data[WIDTH], op[3]}.
- Advance rule: stage k loads from stage k-1 (stage 0 from the input) when stage k is empty or stage k is being emptied downstream in the same cycle.
  - The last stage empties when out_valid && out_ready.
  - Bubbles collapse, so a downstream stall does not block upstream stages that hold empty slots.
- in_ready = !stage0.valid || stage0 advancing. It is combinational from out_ready through the chain; no registered skid buffer.
- Input handshake: a beat is accepted on a rising edge with in_valid && in_ready. in_valid while !in_ready is ignored and the producer holds.
- Latency: a result accepted at edge t is presented at out_valid after edge t+STAGES-1, i.e. STAGES clocks of delay with an unstalled pipe.
- Throughput: 1 beat/clock when out_ready is held high. Simultaneous accept at the input and emit at the output when full is permitted.
- Backpressure: while out_valid && !out_ready, y, y_op and out_valid are held stable.
- Full condition: all stages valid and out_ready=0, giving in_ready=0.
- busy = OR of all stage valid bits.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous). No result is emitted for them.
- Data registers change only on load. Empty stages keep their last data; only the valid bits define occupancy.

Optional Feature:
- Macro: MUX_LOGIC_PIPE_PARITY_EN.
- With it defined:
  - Adds output y_par (1 bit) = XOR-reduction of the stage-0 result.
  - y_par is computed with a mux chain and carried through the pipe aligned with y.
  - Reset value 0; held under backpressure like y.
- Without it: the port and its registers are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mux_logic_pkg holds:
  - op code localparams OP_AND..OP_PASS (3 bits);
  - a stage-record typedef {valid, data, op}.
- One natural sub-module, mux2 (sel, d0, d1, y), used for every gate bit and the parity chain.

Test Plan:
- WIDTH=1, STAGES=2, op=2 (NAND), out_ready=1, sweep a/b 00,01,10,11 -> y = 1,1,1,0, each appearing 2 clocks after acceptance.
- WIDTH=8, op=4, a=8'hF0, b=8'h3C -> y=8'hCC, y_op=4. Then op=6, a=8'hA5 -> y=8'h5A.
- Backpressure: stream 4 beats with out_ready=0 -> after 2 accepts in_ready=0 and y stays at the first result. Raise out_ready -> results emerge in order, one per clock, with none lost or duplicated.
- Throughput: 16 back-to-back beats with out_ready=1 -> in_ready stays 1, and 16 results arrive on consecutive clocks starting at latency 2.
- Reset mid-operation: pipe full, assert rst_n=0 between edges -> out_valid, busy and y go 0 immediately. After release, a new beat (op=0, a=8'hFF, b=8'h0F) yields y=8'h0F.
- With MUX_LOGIC_PIPE_PARITY_EN: op=7, a=8'h07 -> y_par=1 aligned with y=8'h07; a=8'h03 -> y_par=0.
